data_mem_resp: RTL and testbench
================================

# data_mem_resp

Data-memory responder for the rysyCore load/store path. It sits on the other end of the memory request that the control unit issues for LOAD/STORE opcodes, which carries a write enable, `sel_type`, and an ALU-computed address. It performs byte/half/word accesses with RISC-V sign/zero extension, inserts a configurable number of wait states, and returns a one-cycle completion pulse. The core's two-phase load sequencing holds its pipeline until that pulse arrives.

## Interface
- `DEPTH_WORDS`, 1024, memory size in 32-bit words; power of two, ≥ 4
- `WAIT_STATES`, 0, extra access cycles, 0..15
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-low reset
- `req` in 1: request strobe, sampled only when `busy`=0
- `we` in 1: 1 = store, 0 = load
- `sel_type` in 3: access type, equal to RISC-V func3
  - 000 = B
  - 001 = H
  - 010 = W
  - 100 = BU
  - 101 = HU
- `addr` in 32: byte address
- `wdata` in 32: store data, LSB-aligned (byte in [7:0], half in [15:0])
- `rdata` out 32: load result, extended to 32 bits
- `done` out 1: one-cycle completion pulse, for both loads and stores
- `err` out 1: one-cycle error pulse, coincident with `done`
- `busy` out 1: request in flight; `req` ignored while high

## Operation
- States are IDLE, ACCESS, RESP.
- IDLE
  - `req`=1 at an edge: latch `we`, `sel_type`, `addr`, `wdata`; load the wait counter with `WAIT_STATES`; go to ACCESS.
  - `req`=0: stay in IDLE.
- ACCESS
  - Counter ≠ 0: decrement and stay.
  - Counter = 0: perform the access at this edge and go to RESP.
- RESP
  - `done`=1 for exactly this cycle; next edge goes to IDLE.
  - A new `req` is not accepted in RESP; `busy`=1 in ACCESS and RESP.
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias modulo `4*DEPTH_WORDS`.
- Stores
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {`addr[1]`,0} and {`addr[1]`,1} with `wdata[15:0]`.
  - SW writes all lanes.
  - Unwritten lanes are preserved.
  - `rdata`=0 during a store's RESP.
- Loads
  - Select the lane(s) per `addr`, then sign-extend (B/H) or zero-extend (BU/HU); W returns the word.
  - `rdata` is registered and held until the next access completes.
- Errors: the request completes normally through ACCESS/RESP but with `err`=1, `rdata`=0 and no memory write, in these cases:
  - H/HU/SH with `addr[0]`=1
  - W with `addr[1:0]`≠0
  - `sel_type` ∈ {011, 110, 111}
  - store with `sel_type` ∈ {100, 101}
- Memory contents are not initialised and are unaffected by reset.

## Timing
- Reset (`rst`=0 at an edge)
  - State becomes IDLE, counter 0.
  - `done`=0, `err`=0, `busy`=0, `rdata`=0.
  - A latched request is discarded, including a pending write.
  - Reset wins over every other event at the same edge.
- Latency: request accepted at edge N; access at edge N+1+`WAIT_STATES`; `done` high in the cycle following that edge. With `WAIT_STATES`=0, `done` is high 2 cycles after the `req` cycle.
- Throughput: one request per `WAIT_STATES`+3 cycles. The earliest next accept is the edge that ends RESP+1, i.e. `req` held in the first IDLE cycle after `done`.
- `busy` is registered: it rises in the cycle after accept and falls in the cycle after RESP.
- Requests with `req`=1 while `busy`=1 are dropped, not queued. The requester holds `req` until it sees `busy`=0 and then an edge.
- Input fields are only sampled at the accept edge; changes afterwards have no effect.

## Test plan
- Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 with `WAIT_STATES`=0 → `done` 2 cycles after the `req` cycle, `rdata`=0xDEADBEEF, `err`=0.
- After the SW above: SB 0x11 wdata=0x80; LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080; LW 0x10 → 0xDEAD80EF.
- SH 0x22 wdata=0x8001; LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001; LH 0x21 → `err`=1, `rdata`=0, and memory unchanged per a following LW 0x20.
- `WAIT_STATES`=3, LW request → `busy` high 5 cycles; `done` 5 cycles after the accept edge; a second `req` asserted while busy is ignored (exactly one `done`).
- Store with `sel_type`=100 → `err`=1 and no write. Alias check: SW at `4*DEPTH_WORDS`+0x4, then LW 0x4 returns that data.
- `rst`=0 while in ACCESS of SW 0x30 wdata=0x12345678 → next cycle `busy`=0 and `done`=0. After reset release, LW 0x30 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/data_mem_resp_if.sv
// Request/response bundle between the load/store requester and the data-memory responder.
interface data_mem_resp_if;
    logic        req;
    logic        we;
    logic [2:0]  sel_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output req, we, sel_type, addr, wdata,
        input  rdata, done, err, busy
    );

    modport slave (
        input  req, we, sel_type, addr, wdata,
        output rdata, done, err, busy
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: byte/half/word loads and stores with RISC-V extension,
// configurable wait states and a one-cycle done/err completion pulse.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_resp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic [2:0]      sel_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            done_q;
    logic            err_q;
    logic            busy_q;
    logic            rvalid_q;
    logic [2:0]      rsel_q;
    logic [1:0]      rlane_q;

    logic            access_fire;
    logic            acc_err_d;
    logic [3:0]      be_d;
    logic [31:0]     wbytes_d;
    logic [AW-1:0]   widx;
    logic [31:0]     rd_word;
    logic [31:0]     rdata_d;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    assign widx        = addr_q[AW+1:2];
    assign access_fire = rst && (state_q == ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        acc_err_d = 1'b0;
        unique case (sel_q)
            3'b000, 3'b100: acc_err_d = 1'b0;
            3'b001, 3'b101: acc_err_d = addr_q[0];
            3'b010:         acc_err_d = |addr_q[1:0];
            default:        acc_err_d = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (we_q && sel_q[2]) begin
            acc_err_d = 1'b1;
        end

        be_d     = 4'b1111;
        wbytes_d = wdata_q;
        unique case (sel_q[1:0])
            2'b00: begin
                be_d     = 4'b0001 << addr_q[1:0];
                wbytes_d = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_d     = addr_q[1] ? 4'b1100 : 4'b0011;
                wbytes_d = {2{wdata_q[15:0]}};
            end
            default: begin
                be_d     = 4'b1111;
                wbytes_d = wdata_q;
            end
        endcase
    end

    // One byte-wide RAM per lane so byte enables map onto plain write enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH_WORDS];
            logic [7:0] rd_lane_q;

            always_ff @(posedge clk) begin
                if (access_fire && we_q && !acc_err_d && be_d[gi]) begin
                    mem_q[widx] <= wbytes_d[gi*8 +: 8];
                end
                if (access_fire && !we_q) begin
                    rd_lane_q <= mem_q[widx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_lane_q;
        end
    endgenerate

    always_comb begin
        unique case (rlane_q)
            2'd0:    rbyte = rd_word[7:0];
            2'd1:    rbyte = rd_word[15:8];
            2'd2:    rbyte = rd_word[23:16];
            default: rbyte = rd_word[31:24];
        endcase
        rhalf = rlane_q[1] ? rd_word[31:16] : rd_word[15:0];

        rdata_d = 32'd0;
        if (rvalid_q) begin
            unique case (rsel_q)
                3'b000:  rdata_d = {{24{rbyte[7]}}, rbyte};
                3'b100:  rdata_d = {24'd0, rbyte};
                3'b001:  rdata_d = {{16{rhalf[15]}}, rhalf};
                3'b101:  rdata_d = {16'd0, rhalf};
                3'b010:  rdata_d = rd_word;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.req) begin
                        we_q    <= bus.we;
                        sel_q   <= bus.sel_type;
                        addr_q  <= bus.addr[AW+1:0];
                        wdata_q <= bus.wdata;
                        cnt_q   <= 4'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        done_q   <= 1'b1;
                        err_q    <= acc_err_d;
                        rvalid_q <= !we_q && !acc_err_d;
                        rsel_q   <= sel_q;
                        rlane_q  <= addr_q[1:0];
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rdata = rdata_d;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: two instances (0 and 3 wait states) share one
// stimulus driver; expected responses are queued at request time and popped on done.
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  sel = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        tgt = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_resp_if bus0();
    data_mem_resp_if bus3();

    assign bus0.req      = req & ~tgt;
    assign bus3.req      = req & tgt;
    assign bus0.we       = we;
    assign bus3.we       = we;
    assign bus0.sel_type = sel;
    assign bus3.sel_type = sel;
    assign bus0.addr     = addr;
    assign bus3.addr     = addr;
    assign bus0.wdata    = wdata;
    assign bus3.wdata    = wdata;

    wire        done_m  = tgt ? bus3.done  : bus0.done;
    wire        err_m   = tgt ? bus3.err   : bus0.err;
    wire        busy_m  = tgt ? bus3.busy  : bus0.busy;
    wire [31:0] rdata_m = tgt ? bus3.rdata : bus0.rdata;

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; hold keeps req asserted until done is seen.
    task automatic txn(input logic t, input logic w, input logic [2:0] st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input logic hold);
        int   cyc;
        int   busy_n;
        logic got;
        int   lat;
        exp_t e;
        @(negedge clk);
        tgt = t; we = w; sel = st; addr = a; wdata = wd; req = 1'b1;
        sb.push_back('{er, ee});
        lat = t ? 5 : 2;
        cyc = 0; busy_n = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) req = 1'b0;
            if (busy_m) busy_n++;
            if (done_m) got = 1'b1;
        end
        req = 1'b0;
        e = sb.pop_front();
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("rdata", rdata_m, e.rdata);
            check("err", 32'(err_m), 32'(e.err));
            check("latency", 32'(cyc), 32'(lat));
            check("busy_cycles", 32'(busy_n), 32'(lat));
        end
        @(negedge clk);
        check("done_pulse_end", 32'(done_m), 32'd0);
        check("busy_after", 32'(busy_m), 32'd0);
        $display("txn dut%0d we=%0b sel=%03b addr=%h wdata=%h -> rdata=%h err=%0b cyc=%0d",
                 t ? 3 : 0, w, st, a, wd, e.rdata, e.err, cyc);
    endtask

    initial begin
        int extra;
        repeat (3) @(negedge clk);
        check("rst_busy0", 32'(bus0.busy), 32'd0);
        check("rst_done0", 32'(bus0.done), 32'd0);
        check("rst_err0", 32'(bus0.err), 32'd0);
        check("rst_rdata0", bus0.rdata, 32'd0);
        check("rst_busy3", 32'(bus3.busy), 32'd0);
        rst = 1'b1;

        // dut0: word, byte and half accesses
        txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        txn(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        txn(0, 1, 3'b000, 32'h11, 32'h80, 32'h0, 0, 0);
        txn(0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0, 0);
        txn(0, 0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0, 0);
        txn(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, 0);
        txn(0, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 0);
        txn(0, 1, 3'b001, 32'h22, 32'h8001, 32'h0, 0, 0);
        txn(0, 0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0, 0);
        txn(0, 0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0, 0);
        txn(0, 0, 3'b001, 32'h21, 32'h0, 32'h0, 1, 0);
        txn(0, 1, 3'b001, 32'h21, 32'hFFFF, 32'h0, 1, 0);
        txn(0, 0, 3'b010, 32'h20, 32'h0, 32'h80013344, 0, 0);
        txn(0, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 0);
        txn(0, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1, 0);

        // Unsigned store is illegal and must not write
        txn(0, 1, 3'b010, 32'h40, 32'hAAAAAAAA, 32'h0, 0, 0);
        txn(0, 1, 3'b100, 32'h40, 32'h55, 32'h0, 1, 0);
        txn(0, 0, 3'b010, 32'h40, 32'h0, 32'hAAAAAAAA, 0, 0);

        // Aliasing modulo 4*DEPTH_WORDS bytes
        txn(0, 1, 3'b010, 32'h1004, 32'h0BADF00D, 32'h0, 0, 0);
        txn(0, 0, 3'b010, 32'h4, 32'h0, 32'h0BADF00D, 0, 0);

        // dut3: wait states, req held while busy must yield exactly one done
        txn(1, 1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 0, 0);
        txn(1, 0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 0, 1);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_m) extra++;
        end
        check("extra_done", 32'(extra), 32'd0);
        check("rdata_held", rdata_m, 32'hCAFEF00D);

        // Reset in the middle of ACCESS discards the pending store
        @(negedge clk);
        tgt = 1; we = 1; sel = 3'b010; addr = 32'h30; wdata = 32'h12345678; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("abort_busy_pre", 32'(busy_m), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_done", 32'(done_m), 32'd0);
        check("abort_rdata", rdata_m, 32'd0);
        rst = 1'b1;
        $display("txn dut3 reset during ACCESS of SW 0x30");
        txn(1, 0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
